// File: rtl/cmd_queue_v2_0_0_axil_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmd_queue_v2_0_0_axil_pkg
// Shared state encoding and response codes for the AXI-Lite register bridge.
// Revision: 1.0
// ----------------------------------------------------------------------------
package cmd_queue_v2_0_0_axil_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_WR_REQ  = 3'd1;
  localparam state_t ST_WR_WAIT = 3'd2;
  localparam state_t ST_WR_RESP = 3'd3;
  localparam state_t ST_RD_REQ  = 3'd4;
  localparam state_t ST_RD_WAIT = 3'd5;
  localparam state_t ST_RD_RESP = 3'd6;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  // Read data returned when a read is abandoned by the timeout
  localparam logic [31:0] TIMEOUT_DATA = 32'h0000_0000;

endpackage
`default_nettype wire

// File: rtl/cmd_queue_v2_0_0_reg_timeout.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmd_queue_v2_0_0_reg_timeout
// Wait-cycle counter; expired flags the last allowed WAIT cycle.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cmd_queue_v2_0_0_reg_timeout #(
  parameter int C_TIMEOUT_CYCLES = 256
) (
  input  logic aclk,
  input  logic aresetn,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  generate
    if (C_TIMEOUT_CYCLES == 0) begin : g_disabled
      logic w_unused;
      assign w_unused = ^{aclk, aresetn, clear, enable};
      assign expired  = 1'b0;
    end else begin : g_counter
      localparam int C_CNT_W = $clog2(C_TIMEOUT_CYCLES + 1);

      logic [C_CNT_W-1:0] r_count;

      // r_count holds the number of WAIT cycles already spent before this one
      assign expired = enable && (r_count == C_CNT_W'(C_TIMEOUT_CYCLES - 1));

      always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
          r_count <= '0;
        end else if (clear) begin
          r_count <= '0;
        end else if (enable && !expired) begin
          r_count <= r_count + 1'b1;
        end
      end
    end
  endgenerate

endmodule
`default_nettype wire

// File: rtl/cmd_queue_v2_0_0_axil_reg_bridge.sv
`default_nettype none
// ----------------------------------------------------------------------------
// cmd_queue_v2_0_0_axil_reg_bridge
// AXI4-Lite subordinate to single-outstanding register request/done bridge.
// Revision: 1.0
// ----------------------------------------------------------------------------
module cmd_queue_v2_0_0_axil_reg_bridge
  import cmd_queue_v2_0_0_axil_pkg::*;
#(
  parameter int C_DATA_WIDTH     = 32,
  parameter int C_ADDR_WIDTH     = 32,
  parameter int C_TIMEOUT_CYCLES = 256
) (
  input  logic                      aclk,
  input  logic                      aresetn,
  input  logic                      s_axil_awvalid,
  output logic                      s_axil_awready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axil_awaddr,
  input  logic                      s_axil_wvalid,
  output logic                      s_axil_wready,
  input  logic [C_DATA_WIDTH-1:0]   s_axil_wdata,
  input  logic [C_DATA_WIDTH/8-1:0] s_axil_wstrb,
  output logic                      s_axil_bvalid,
  input  logic                      s_axil_bready,
  output logic [1:0]                s_axil_bresp,
  input  logic                      s_axil_arvalid,
  output logic                      s_axil_arready,
  input  logic [C_ADDR_WIDTH-1:0]   s_axil_araddr,
  output logic                      s_axil_rvalid,
  input  logic                      s_axil_rready,
  output logic [C_DATA_WIDTH-1:0]   s_axil_rdata,
  output logic [1:0]                s_axil_rresp,
  output logic                      reg_rd_valid,
  output logic [C_ADDR_WIDTH-1:0]   reg_rd_addr,
  input  logic                      reg_rd_done,
  input  logic [1:0]                reg_rd_resp,
  input  logic [C_DATA_WIDTH-1:0]   reg_rd_data,
  output logic                      reg_wr_valid,
  output logic [C_ADDR_WIDTH-1:0]   reg_wr_addr,
  output logic [C_DATA_WIDTH/8-1:0] reg_wr_be,
  output logic [C_DATA_WIDTH-1:0]   reg_wr_data,
  input  logic                      reg_wr_done,
  input  logic [1:0]                reg_wr_resp
);

  state_t                    r_state;
  logic                      r_run;
  logic                      r_last_rd;
  logic                      r_aw_held;
  logic                      r_w_held;
  logic [C_ADDR_WIDTH-1:0]   r_awaddr;
  logic [C_DATA_WIDTH-1:0]   r_wdata;
  logic [C_DATA_WIDTH/8-1:0] r_wstrb;
  logic                      r_bvalid;
  logic [1:0]                r_bresp;
  logic                      r_rvalid;
  logic [1:0]                r_rresp;
  logic [C_DATA_WIDTH-1:0]   r_rdata;
  logic                      r_rd_valid;
  logic [C_ADDR_WIDTH-1:0]   r_rd_addr;
  logic                      r_wr_valid;
  logic [C_ADDR_WIDTH-1:0]   r_wr_addr;
  logic [C_DATA_WIDTH/8-1:0] r_wr_be;
  logic [C_DATA_WIDTH-1:0]   r_wr_data;

  logic w_idle;
  logic w_awready;
  logic w_wready;
  logic w_arready;
  logic w_aw_hs;
  logic w_w_hs;
  logic w_ar_hs;
  logic w_wr_complete;
  logic w_wr_partial;
  logic w_wr_pick;
  logic w_req_state;
  logic w_wait_state;
  logic w_expired;

  // r_run keeps every ready low until the first edge after reset release
  always_comb begin
    w_idle        = (r_state == ST_IDLE) && r_run;
    w_awready     = w_idle && !r_aw_held;
    w_wready      = w_idle && !r_w_held;
    w_aw_hs       = w_awready && s_axil_awvalid;
    w_w_hs        = w_wready && s_axil_wvalid;
    w_wr_complete = (r_aw_held || w_aw_hs) && (r_w_held || w_w_hs);
    w_wr_partial  = r_aw_held ^ r_w_held;
    // A complete write only yields to a read when the last grant went to a write
    w_wr_pick     = w_wr_complete && r_last_rd;
    w_arready     = w_idle && !w_wr_partial && !w_wr_pick;
    w_ar_hs       = w_arready && s_axil_arvalid;
    w_req_state   = (r_state == ST_WR_REQ) || (r_state == ST_RD_REQ);
    w_wait_state  = (r_state == ST_WR_WAIT) || (r_state == ST_RD_WAIT);
  end

  cmd_queue_v2_0_0_reg_timeout #(
    .C_TIMEOUT_CYCLES (C_TIMEOUT_CYCLES)
  ) u_timeout (
    .aclk    (aclk),
    .aresetn (aresetn),
    .clear   (w_req_state),
    .enable  (w_wait_state),
    .expired (w_expired)
  );

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      r_state    <= ST_IDLE;
      r_run      <= 1'b0;
      r_last_rd  <= 1'b0;
      r_aw_held  <= 1'b0;
      r_w_held   <= 1'b0;
      r_awaddr   <= '0;
      r_wdata    <= '0;
      r_wstrb    <= '0;
      r_bvalid   <= 1'b0;
      r_bresp    <= RESP_OKAY;
      r_rvalid   <= 1'b0;
      r_rresp    <= RESP_OKAY;
      r_rdata    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_addr  <= '0;
      r_wr_valid <= 1'b0;
      r_wr_addr  <= '0;
      r_wr_be    <= '0;
      r_wr_data  <= '0;
    end else begin
      r_run      <= 1'b1;
      r_rd_valid <= 1'b0;
      r_wr_valid <= 1'b0;

      if (w_aw_hs) begin
        r_aw_held <= 1'b1;
        r_awaddr  <= s_axil_awaddr;
      end
      if (w_w_hs) begin
        r_w_held <= 1'b1;
        r_wdata  <= s_axil_wdata;
        r_wstrb  <= s_axil_wstrb;
      end

      case (r_state)
        ST_IDLE: begin
          if (w_ar_hs) begin
            r_state    <= ST_RD_REQ;
            r_rd_valid <= 1'b1;
            r_rd_addr  <= s_axil_araddr;
          end else if (w_wr_complete) begin
            // Holding registers are not yet loaded when the final handshake is this cycle
            r_state    <= ST_WR_REQ;
            r_wr_valid <= 1'b1;
            r_wr_addr  <= w_aw_hs ? s_axil_awaddr : r_awaddr;
            r_wr_data  <= w_w_hs ? s_axil_wdata : r_wdata;
            r_wr_be    <= w_w_hs ? s_axil_wstrb : r_wstrb;
          end
        end
        ST_WR_REQ: r_state <= ST_WR_WAIT;
        ST_WR_WAIT: begin
          if (reg_wr_done) begin
            r_bresp  <= reg_wr_resp;
            r_bvalid <= 1'b1;
            r_state  <= ST_WR_RESP;
          end else if (w_expired) begin
            r_bresp  <= RESP_SLVERR;
            r_bvalid <= 1'b1;
            r_state  <= ST_WR_RESP;
          end
        end
        ST_WR_RESP: begin
          if (s_axil_bready) begin
            r_bvalid  <= 1'b0;
            r_aw_held <= 1'b0;
            r_w_held  <= 1'b0;
            r_last_rd <= 1'b0;
            r_state   <= ST_IDLE;
          end
        end
        ST_RD_REQ: r_state <= ST_RD_WAIT;
        ST_RD_WAIT: begin
          if (reg_rd_done) begin
            r_rresp  <= reg_rd_resp;
            r_rdata  <= reg_rd_data;
            r_rvalid <= 1'b1;
            r_state  <= ST_RD_RESP;
          end else if (w_expired) begin
            r_rresp  <= RESP_SLVERR;
            r_rdata  <= C_DATA_WIDTH'(TIMEOUT_DATA);
            r_rvalid <= 1'b1;
            r_state  <= ST_RD_RESP;
          end
        end
        ST_RD_RESP: begin
          if (s_axil_rready) begin
            r_rvalid  <= 1'b0;
            r_last_rd <= 1'b1;
            r_state   <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign s_axil_awready = w_awready;
  assign s_axil_wready  = w_wready;
  assign s_axil_arready = w_arready;
  assign s_axil_bvalid  = r_bvalid;
  assign s_axil_bresp   = r_bresp;
  assign s_axil_rvalid  = r_rvalid;
  assign s_axil_rresp   = r_rresp;
  assign s_axil_rdata   = r_rdata;
  assign reg_rd_valid   = r_rd_valid;
  assign reg_rd_addr    = r_rd_addr;
  assign reg_wr_valid   = r_wr_valid;
  assign reg_wr_addr    = r_wr_addr;
  assign reg_wr_be      = r_wr_be;
  assign reg_wr_data    = r_wr_data;

endmodule
`default_nettype wire

// File: tb/tb_cmd_queue_v2_0_0_axil_reg_bridge.sv
`timescale 1ns/1ps
`default_nettype none
// ----------------------------------------------------------------------------
// tb_cmd_queue_v2_0_0_axil_reg_bridge
// Scoreboard bench: stimulus queues expected requests/responses, monitors pop and compare.
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_cmd_queue_v2_0_0_axil_reg_bridge;
  import cmd_queue_v2_0_0_axil_pkg::*;

  localparam int C_TO = 8;

  logic        aclk = 1'b0;
  logic        aresetn = 1'b1;
  logic        s_axil_awvalid = 1'b0, s_axil_awready;
  logic [31:0] s_axil_awaddr = '0;
  logic        s_axil_wvalid = 1'b0, s_axil_wready;
  logic [31:0] s_axil_wdata = '0;
  logic [3:0]  s_axil_wstrb = '0;
  logic        s_axil_bvalid, s_axil_bready = 1'b1;
  logic [1:0]  s_axil_bresp;
  logic        s_axil_arvalid = 1'b0, s_axil_arready;
  logic [31:0] s_axil_araddr = '0;
  logic        s_axil_rvalid, s_axil_rready = 1'b1;
  logic [31:0] s_axil_rdata;
  logic [1:0]  s_axil_rresp;
  logic        reg_rd_valid, reg_rd_done = 1'b0;
  logic [31:0] reg_rd_addr, reg_rd_data = '0;
  logic [1:0]  reg_rd_resp = '0;
  logic        reg_wr_valid, reg_wr_done = 1'b0;
  logic [31:0] reg_wr_addr, reg_wr_data;
  logic [3:0]  reg_wr_be;
  logic [1:0]  reg_wr_resp = '0;

  cmd_queue_v2_0_0_axil_reg_bridge #(
    .C_DATA_WIDTH(32), .C_ADDR_WIDTH(32), .C_TIMEOUT_CYCLES(C_TO)
  ) dut (
    .aclk(aclk), .aresetn(aresetn),
    .s_axil_awvalid(s_axil_awvalid), .s_axil_awready(s_axil_awready), .s_axil_awaddr(s_axil_awaddr),
    .s_axil_wvalid(s_axil_wvalid), .s_axil_wready(s_axil_wready), .s_axil_wdata(s_axil_wdata),
    .s_axil_wstrb(s_axil_wstrb),
    .s_axil_bvalid(s_axil_bvalid), .s_axil_bready(s_axil_bready), .s_axil_bresp(s_axil_bresp),
    .s_axil_arvalid(s_axil_arvalid), .s_axil_arready(s_axil_arready), .s_axil_araddr(s_axil_araddr),
    .s_axil_rvalid(s_axil_rvalid), .s_axil_rready(s_axil_rready), .s_axil_rdata(s_axil_rdata),
    .s_axil_rresp(s_axil_rresp),
    .reg_rd_valid(reg_rd_valid), .reg_rd_addr(reg_rd_addr), .reg_rd_done(reg_rd_done),
    .reg_rd_resp(reg_rd_resp), .reg_rd_data(reg_rd_data),
    .reg_wr_valid(reg_wr_valid), .reg_wr_addr(reg_wr_addr), .reg_wr_be(reg_wr_be),
    .reg_wr_data(reg_wr_data), .reg_wr_done(reg_wr_done), .reg_wr_resp(reg_wr_resp)
  );

  always #5 aclk = ~aclk;

  int cyc = 0;
  always @(posedge aclk) cyc <= cyc + 1;

  typedef struct {
    bit          wr;
    logic [31:0] addr;
    logic [31:0] data;
    logic [3:0]  be;
    int          delay;   // cycles after valid to assert done; -1 = never
    logic [1:0]  resp;
    logic [31:0] rdata;
  } req_t;

  typedef struct {
    logic [1:0]  resp;
    logic [31:0] data;
    int          lat;     // cycles from reg_*_valid to first bvalid/rvalid
  } rsp_t;

  req_t req_q[$];
  rsp_t b_q[$];
  rsp_t r_q[$];

  int n_cmp = 0;
  int n_fail = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, want 0x%08h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // ---------------- register subordinate model ----------------
  req_t        cur_req;
  int          req_cyc = 0;
  int          done_at = 0;
  bit          pend = 1'b0;
  bit          pend_wr = 1'b0;
  logic [1:0]  pend_resp = '0;
  logic [31:0] pend_data = '0;
  int          stray_at = -1;

  initial forever begin
    @(negedge aclk);
    if (reg_wr_valid || reg_rd_valid) begin
      check("req_both", 32'(reg_wr_valid & reg_rd_valid), 32'd0);
      if (req_q.size() == 0) begin
        check("req_spurious", {30'd0, reg_wr_valid, reg_rd_valid}, 32'd0);
      end else begin
        cur_req = req_q.pop_front();
        check("req_kind_wr", 32'(reg_wr_valid), 32'(cur_req.wr));
        if (cur_req.wr) begin
          check("wr_addr", reg_wr_addr, cur_req.addr);
          check("wr_data", reg_wr_data, cur_req.data);
          check("wr_be", 32'(reg_wr_be), 32'(cur_req.be));
        end else begin
          check("rd_addr", reg_rd_addr, cur_req.addr);
        end
        req_cyc   = cyc;
        pend      = (cur_req.delay >= 0);
        done_at   = cyc + cur_req.delay;
        pend_wr   = cur_req.wr;
        pend_resp = cur_req.resp;
        pend_data = cur_req.rdata;
      end
    end
  end

  initial forever begin
    @(posedge aclk);
    #1;
    reg_wr_done = 1'b0; reg_wr_resp = 2'b00;
    reg_rd_done = 1'b0; reg_rd_resp = 2'b00; reg_rd_data = '0;
    if (cyc == stray_at) begin
      reg_wr_done = 1'b1; reg_wr_resp = 2'b11;
      reg_rd_done = 1'b1; reg_rd_resp = 2'b11; reg_rd_data = 32'hFFFF_FFFF;
    end else if (pend && cyc == done_at) begin
      if (pend_wr) begin
        reg_wr_done = 1'b1; reg_wr_resp = pend_resp;
      end else begin
        reg_rd_done = 1'b1; reg_rd_resp = pend_resp; reg_rd_data = pend_data;
      end
    end
  end

  // ---------------- response monitors ----------------
  bit   b_prev = 1'b0, b_hs_prev = 1'b0, r_prev = 1'b0, r_hs_prev = 1'b0;
  rsp_t b_exp, r_exp;

  initial forever begin
    @(negedge aclk);
    if (b_prev && !b_hs_prev) check("b_valid_held", 32'(s_axil_bvalid), 32'd1);
    if (b_q.size() == 0) begin
      check("b_spurious", 32'(s_axil_bvalid), 32'd0);
    end else if (s_axil_bvalid) begin
      b_exp = b_q[0];
      if (!b_prev) check("b_latency", 32'(cyc - req_cyc), 32'(b_exp.lat));
      check("bresp", 32'(s_axil_bresp), 32'(b_exp.resp));
      if (s_axil_bready) void'(b_q.pop_front());
    end
    b_prev    = s_axil_bvalid;
    b_hs_prev = s_axil_bvalid && s_axil_bready;

    if (r_prev && !r_hs_prev) check("r_valid_held", 32'(s_axil_rvalid), 32'd1);
    if (r_q.size() == 0) begin
      check("r_spurious", 32'(s_axil_rvalid), 32'd0);
    end else if (s_axil_rvalid) begin
      r_exp = r_q[0];
      if (!r_prev) check("r_latency", 32'(cyc - req_cyc), 32'(r_exp.lat));
      check("rresp", 32'(s_axil_rresp), 32'(r_exp.resp));
      check("rdata", s_axil_rdata, r_exp.data);
      if (s_axil_rready) void'(r_q.pop_front());
    end
    r_prev    = s_axil_rvalid;
    r_hs_prev = s_axil_rvalid && s_axil_rready;
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) begin @(posedge aclk); #1; end
  endtask

  task automatic do_aw(input logic [31:0] a, input int dly);
    bit hs; int n;
    tick(dly);
    s_axil_awvalid = 1'b1; s_axil_awaddr = a;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge aclk); hs = s_axil_awready;
      @(posedge aclk); #1; n++;
    end
    s_axil_awvalid = 1'b0;
    if (!hs) check("aw_hs_timeout", 32'(s_axil_awready), 32'd1);
  endtask

  task automatic do_w(input logic [31:0] d, input logic [3:0] s, input int dly);
    bit hs; int n;
    tick(dly);
    s_axil_wvalid = 1'b1; s_axil_wdata = d; s_axil_wstrb = s;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge aclk); hs = s_axil_wready;
      @(posedge aclk); #1; n++;
    end
    s_axil_wvalid = 1'b0;
    if (!hs) check("w_hs_timeout", 32'(s_axil_wready), 32'd1);
  endtask

  task automatic do_ar(input logic [31:0] a, input int dly);
    bit hs; int n;
    tick(dly);
    s_axil_arvalid = 1'b1; s_axil_araddr = a;
    hs = 1'b0; n = 0;
    while (!hs && n < 100) begin
      @(negedge aclk); hs = s_axil_arready;
      @(posedge aclk); #1; n++;
    end
    s_axil_arvalid = 1'b0;
    if (!hs) check("ar_hs_timeout", 32'(s_axil_arready), 32'd1);
  endtask

  task automatic do_write(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s,
                          input int aw_dly, input int w_dly);
    fork
      do_aw(a, aw_dly);
      do_w(d, s, w_dly);
    join
  endtask

  task automatic exp_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be,
                        input int dly, input logic [1:0] resp, input int lat);
    req_q.push_back('{wr: 1'b1, addr: a, data: d, be: be, delay: dly, resp: resp, rdata: 32'h0});
    b_q.push_back('{resp: (dly < 0) ? RESP_SLVERR : resp, data: 32'h0, lat: lat});
  endtask

  task automatic exp_rd(input logic [31:0] a, input int dly, input logic [1:0] resp,
                        input logic [31:0] rd, input int lat, input bit with_rsp);
    req_q.push_back('{wr: 1'b0, addr: a, data: 32'h0, be: 4'h0, delay: dly, resp: resp, rdata: rd});
    if (with_rsp) r_q.push_back('{resp: resp, data: rd, lat: lat});
  endtask

  task automatic drain();
    int n;
    n = 0;
    while ((req_q.size() + b_q.size() + r_q.size()) != 0 && n < 300) begin
      tick(1); n++;
    end
    if (n >= 300) check("drain_timeout", 32'(req_q.size() + b_q.size() + r_q.size()), 32'd0);
    tick(2);
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_ctrl"}, {25'd0, s_axil_awready, s_axil_wready, s_axil_arready,
                           s_axil_bvalid, s_axil_rvalid, reg_rd_valid, reg_wr_valid}, 32'd0);
    check({tag, "_resp"}, {28'd0, s_axil_bresp, s_axil_rresp}, 32'd0);
    check({tag, "_rdata"}, s_axil_rdata, 32'd0);
    check({tag, "_rd_addr"}, reg_rd_addr, 32'd0);
    check({tag, "_wr_addr"}, reg_wr_addr, 32'd0);
    check({tag, "_wr_data"}, reg_wr_data, 32'd0);
    check({tag, "_wr_be"}, 32'(reg_wr_be), 32'd0);
  endtask

  task automatic pulse_reset();
    aresetn = 1'b0;
    tick(2);
    aresetn = 1'b1;
    tick(2);
  endtask

  // ---------------- directed sequence ----------------
  initial begin : stim
    int n;
    #1 aresetn = 1'b0;
    tick(2);
    check_reset_outputs("reset");
    aresetn = 1'b1;
    tick(2);

    // single write, done two cycles after valid
    exp_wr(32'h10, 32'hA5A5_0001, 4'hF, 2, RESP_OKAY, 3);
    do_write(32'h10, 32'hA5A5_0001, 4'hF, 0, 0);
    drain();

    // AW five cycles ahead of W; a read arriving meanwhile must wait
    exp_wr(32'h30, 32'h1234_5678, 4'h3, 1, RESP_OKAY, 2);
    exp_rd(32'h34, 3, RESP_OKAY, 32'h0BAD_F00D, 4, 1'b1);
    fork
      do_write(32'h30, 32'h1234_5678, 4'h3, 0, 5);
      do_ar(32'h34, 2);
      begin
        tick(3);
        @(negedge aclk);
        check("partial_awready", 32'(s_axil_awready), 32'd0);
        check("partial_arready", 32'(s_axil_arready), 32'd0);
      end
    join
    drain();

    // DECERR read with rready held off for four cycles
    exp_rd(32'h20, 2, RESP_DECERR, 32'hDEAD_BEEF, 3, 1'b1);
    s_axil_rready = 1'b0;
    do_ar(32'h20, 0);
    n = 0;
    while (!s_axil_rvalid && n < 50) begin tick(1); n++; end
    if (!s_axil_rvalid) check("rvalid_wait_timeout", 32'(s_axil_rvalid), 32'd1);
    tick(4);
    s_axil_rready = 1'b1;
    drain();

    // contention from reset: expected order R, W, R, W
    pulse_reset();
    exp_rd(32'h64, 1, RESP_OKAY,   32'h2222_0000, 2, 1'b1);
    exp_wr(32'h60, 32'h1111_0000, 4'hF, 1, RESP_OKAY, 2);
    exp_rd(32'h6C, 2, RESP_DECERR, 32'h4444_0000, 3, 1'b1);
    exp_wr(32'h68, 32'h3333_0000, 4'hC, 2, RESP_SLVERR, 3);
    fork
      begin
        do_write(32'h60, 32'h1111_0000, 4'hF, 0, 0);
        do_write(32'h68, 32'h3333_0000, 4'hC, 0, 0);
      end
      begin
        do_ar(32'h64, 0);
        do_ar(32'h6C, 0);
      end
    join
    drain();

    // silent subordinate: SLVERR after C_TO wait cycles, then done exactly at the boundary
    exp_wr(32'h40, 32'hDEAD_0040, 4'hF, -1, RESP_OKAY, C_TO + 1);
    do_write(32'h40, 32'hDEAD_0040, 4'hF, 0, 0);
    drain();
    exp_rd(32'h44, C_TO, RESP_OKAY, 32'h5555_AAAA, C_TO + 1, 1'b1);
    do_ar(32'h44, 0);
    drain();

    // stray done while idle is ignored
    stray_at = cyc + 1;
    tick(6);

    // reset during RD_WAIT aborts without a response
    exp_rd(32'h50, -1, RESP_OKAY, 32'h0, 0, 1'b0);
    do_ar(32'h50, 0);
    n = 0;
    while (req_q.size() != 0 && n < 50) begin tick(1); n++; end
    if (req_q.size() != 0) check("abort_req_timeout", 32'(req_q.size()), 32'd0);
    tick(3);
    aresetn = 1'b0;
    #1;
    check_reset_outputs("abort");
    tick(2);
    aresetn = 1'b1;
    tick(C_TO + 4);
    exp_rd(32'h54, 2, RESP_OKAY, 32'hCAFE_0001, 3, 1'b1);
    do_ar(32'h54, 0);
    drain();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not complete, got timeout, want finish");
    $fatal(1);
  end

endmodule
`default_nettype wire

// File: doc/cmd_queue_v2_0_0_axil_reg_bridge.md
# cmd_queue_v2_0_0_axil_reg_bridge

AXI4-Lite subordinate that converts host register accesses into single-outstanding transactions on the register manager interface (reg_rd_*/reg_wr_* signals, `man` side). It sits between the host AXI4-Lite crossbar and the command-queue register file, which implements the `sub` side. The bridge:
- serialises reads and writes;
- arbitrates fairly between them;
- converts a stalled subordinate into an SLVERR response via a timeout.

## Interface
Parameters:
- C_DATA_WIDTH, 32: data width of AXI-Lite and reg interface; only 32 is supported.
- C_ADDR_WIDTH, 32: address width of both sides.
- C_TIMEOUT_CYCLES, 256: cycles to wait for done before forcing SLVERR; 0 disables the timeout.

Ports:
- Clock and reset: one clock; reset is asynchronous and active-low.
  - aclk  in  1  clock.
  - aresetn  in  1  asynchronous active-low reset.
- AXI-Lite write address and data:
  - s_axil_awvalid/awready  in/out  1  write address handshake.
  - s_axil_awaddr  in  C_ADDR_WIDTH  write address.
  - s_axil_wvalid/wready  in/out  1  write data handshake.
  - s_axil_wdata  in  C_DATA_WIDTH  write data.
  - s_axil_wstrb  in  C_DATA_WIDTH/8  byte strobes.
- AXI-Lite write response:
  - s_axil_bvalid/bready  out/in  1  write response handshake.
  - s_axil_bresp  out  2  write response.
- AXI-Lite read:
  - s_axil_arvalid/arready  in/out  1  read address handshake.
  - s_axil_araddr  in  C_ADDR_WIDTH  read address.
  - s_axil_rvalid/rready  out/in  1  read data handshake.
  - s_axil_rdata  out  C_DATA_WIDTH  read data.
  - s_axil_rresp  out  2  read response.
- Register read channel:
  - reg_rd_valid  out  1  one-cycle read request pulse.
  - reg_rd_addr  out  C_ADDR_WIDTH  read address.
  - reg_rd_done  in  1  read complete.
  - reg_rd_resp  in  2  read response.
  - reg_rd_data  in  C_DATA_WIDTH  read data.
- Register write channel:
  - reg_wr_valid  out  1  one-cycle write request pulse.
  - reg_wr_addr  out  C_ADDR_WIDTH  write address.
  - reg_wr_be  out  C_DATA_WIDTH/8  byte enables = wstrb.
  - reg_wr_data  out  C_DATA_WIDTH  write data.
  - reg_wr_done  in  1  write complete.
  - reg_wr_resp  in  2  write response.

## Operation
FSM states:
- IDLE:
  - awready = !aw_held; wready = !w_held.
  - arready = !aw_held && !w_held && !wr_pick.
  - AW and W are captured independently into holding registers.
- Arbitration, when both a complete write (aw_held & w_held) and arvalid are pending:
  - Round-robin; the last_rd flag selects the other type.
  - After reset, read wins first.
  - A partially captured write blocks arready until it completes.
- WR_REQ: drive reg_wr_valid for exactly one cycle with the held addr/be/data, then go to WR_WAIT.
- RD_REQ: the same for reads, using reg_rd_valid and the captured araddr.
- WR_WAIT / RD_WAIT:
  - Sample done each cycle.
  - On done, capture resp (and data for reads), then go to WR_RESP / RD_RESP.
  - On timeout expiry, capture resp = 2'b10 and rdata = 0.
- WR_RESP / RD_RESP:
  - bvalid / rvalid is held with stable payload until bready / rready.
  - Then clear the holding registers, update last_rd, and go to IDLE.
- Addr/be/data outputs hold their last value outside REQ.
- done/resp/data inputs are ignored outside WAIT states, including a stray done in IDLE.
- The subordinate must not assert done after a timeout.
- resp passes through unchanged: 00 OKAY, 10 SLVERR, 11 DECERR.

## Timing
- Reset values: all ready/valid outputs 0; bresp, rresp, rdata, reg_* addr/be/data 0; state IDLE; last_rd 0.
- aresetn assertion mid-transaction aborts immediately. No response is issued for the aborted access.
- Write latency:
  - AW&W final handshake at cycle T.
  - reg_wr_valid at T+1.
  - done sampled from T+2.
  - done at cycle D gives bvalid at D+1.
- Read latency:
  - AR handshake at T.
  - reg_rd_valid at T+1.
  - done at D gives rvalid at D+1.
  - Minimum AR-to-rvalid latency: 3 cycles.
- The subordinate asserts done no earlier than the cycle after valid. done in the same cycle as valid is not sampled.
- Timeout counter:
  - Clears on REQ entry and increments each WAIT cycle.
  - Expires when it reaches C_TIMEOUT_CYCLES without done, and the response is forced that cycle.
  - If done and expiry coincide, done wins.
- Next request is accepted no earlier than the cycle after the B/R handshake. There is at most one outstanding access.

## Structure
- Package cmd_queue_v2_0_0_axil_pkg contains:
  - state enum;
  - response constants RESP_OKAY = 2'b00, RESP_SLVERR = 2'b10, RESP_DECERR = 2'b11;
  - timeout data value 0.
- Sub-module cmd_queue_v2_0_0_reg_timeout: a counter with clear/enable inputs and an expired output.
  - Tied off when C_TIMEOUT_CYCLES = 0.

## Test plan
- Single write, addr 0x10, data 0xA5A5_0001, wstrb 0xF; subordinate done 2 cycles after valid with resp 00:
  - one reg_wr_valid pulse with the same addr/data/be;
  - bvalid with bresp 00 three cycles after done's request.
- AW presented 5 cycles before W:
  - awready drops after the AW handshake;
  - arvalid issued meanwhile is not accepted;
  - write completes first.
- Read at 0x20, subordinate returns 0xDEAD_BEEF with resp 11:
  - rdata = 0xDEAD_BEEF, rresp = 11;
  - rready held low 4 cycles: rvalid/rdata stable throughout.
- Simultaneous complete write and read from reset:
  - read is served first, then write;
  - repeated contention alternates R, W, R, W.
- C_TIMEOUT_CYCLES = 8, subordinate never asserts done:
  - bresp = 10 exactly 8 WAIT cycles after reg_wr_valid;
  - a following read with done at the timeout boundary returns OKAY.
- aresetn pulsed low during RD_WAIT:
  - all outputs return to reset values;
  - no rvalid is issued;
  - a fresh read after reset completes normally.
